hex_word_tx: RTL and testbench
==============================

Name: hex_word_tx

Overview:
Parametrised hex-dump serializer. Queues W-bit words in a small FIFO and emits each word as ASCII hex characters over a byte-level strobe/busy handshake. Each word has an optional "0x" prefix and an optional "\r\n" terminator. It sits between debug/bus-capture logic and the team's UART transmitter: o_tx_stb/o_tx_data drive the UART's write strobe and data inputs, and the UART's busy output drives i_tx_busy.

Parameters:
W, 32, data word width; must be a multiple of 4, range 4..64; N = W/4 hex digits per word
DEPTH, 4, word FIFO depth; power of two, 2..64
PREFIX, 1, 1 = emit "0x" before the digits
NEWLINE, 1, 1 = emit "\r" then "\n" after the digits
UPPER, 0, 1 = digits A-F emitted uppercase; 0 = lowercase a-f

Ports:
i_clk  in  1  clock; all logic on its rising edge
i_reset  in  1  synchronous active-high reset
i_stb  in  1  word write request
i_data  in  W  word to print, MSB nibble first
o_busy  out  1  FIFO full; a write is accepted only when i_stb && !o_busy
o_count  out  clog2(DEPTH+1)  words currently held in the FIFO (excludes the word being printed)
o_idle  out  1  FSM in IDLE and FIFO empty
o_tx_stb  out  1  character valid
o_tx_data  out  8  ASCII character
i_tx_busy  in  1  downstream busy; a character is accepted on a cycle where o_tx_stb && !i_tx_busy

Behaviour:
- Reset, synchronous, sampled at a clock edge: FIFO emptied. FSM -> IDLE. After that edge: o_tx_stb=0, o_tx_data=8'h00, o_busy=0, o_count=0, o_idle=1.
- Reset mid-word: the word and the remaining characters are dropped. No further characters until a new write.
- FIFO: a push occurs on i_stb && !o_busy. o_busy = (o_count == DEPTH), registered. A write while full is ignored; there is no overwrite.
- Simultaneous push and pop is legal whenever the FIFO is not full; o_count is then unchanged.
- FSM states: IDLE, PFX0 ('0'), PFX1 ('x'), DIGIT, CR (8'h0D), LF (8'h0A).
- Word start:
  - In IDLE with the FIFO non-empty, pop the head into the shift register and load digit counter = N-1.
  - Next state is PFX0 if PREFIX, else DIGIT.
  - o_tx_stb is asserted from the cycle after the pop.
- Latency: a word pushed into an empty FIFO at edge t is popped at edge t+1. o_tx_stb is high with the first character during cycle t+2.
- Character hold: while o_tx_stb && i_tx_busy, o_tx_data and the state must not change.
- Advance: on acceptance, the next character is presented on the following cycle. o_tx_stb stays high within a word; there are no gap cycles.
- DIGIT state:
  - o_tx_data = ASCII of shift-register nibble [W-1:W-4].
  - On acceptance, shift left by 4 (zero fill) and decrement the counter.
  - After the digit with counter 0, go to CR if NEWLINE, else end of word.
- End of word: on acceptance of the last character, if the FIFO is non-empty, pop immediately and present the next word's first character the next cycle, keeping o_tx_stb high. Otherwise go to IDLE and drop o_tx_stb the next cycle.
- Characters per word: 2*PREFIX + N + 2*NEWLINE.
- Nibble mapping: 0-9 -> 8'h30-8'h39. 10-15 -> 8'h41-8'h46 if UPPER, else 8'h61-8'h66.
- i_tx_busy may toggle arbitrarily, including while o_tx_stb is low; it is ignored when o_tx_stb=0.
- Every o_tx_stb rise is preceded by a pop; no character is emitted without a word.

Test Plan:
1. Defaults: push 32'hDEADBEEF, i_tx_busy=0.
   -> o_tx_stb is high from cycle t+2 for exactly 12 consecutive cycles.
   -> Sequence "0","x","d","e","a","d","b","e","e","f",8'h0D,8'h0A, then o_idle=1.
2. W=16, PREFIX=0, NEWLINE=0, UPPER=1: push 16'h00AF.
   -> Exactly "0","0","A","F". A second push of 16'h0000 gives "0","0","0","0" back-to-back with no gap cycle.
3. Backpressure: defaults; drive i_tx_busy=1 for 3 cycles after each acceptance.
   -> Same 12-character stream as test 1.
   -> o_tx_data is stable whenever o_tx_stb && i_tx_busy.
4. FIFO full: DEPTH=4, hold i_tx_busy=1, push 6 words on consecutive cycles.
   -> Word 1 is popped into the engine; words 2-5 fill the FIFO (o_count=4, o_busy=1); word 6 is dropped.
   -> After releasing busy, exactly 5 words are printed, in push order.
5. Simultaneous push/pop: FIFO at count 2; push on the same cycle as the last-character acceptance.
   -> o_count remains 2. Printing continues seamlessly; o_tx_stb never drops.
6. Reset mid-word: assert i_reset after the 4th character of 32'h12345678 is accepted, with 2 words queued.
   -> o_tx_stb=0, o_count=0, o_idle=1 after the edge. No further characters until a new push.

Source files
------------

// File: rtl/hex_word_tx_if.sv
// hex_word_tx_if: word-write and character-stream signals of the hex-dump serializer.
//   master : producer side (drives words, observes FIFO status and characters,
//            drives downstream busy back in)
//   slave  : serializer side
//   i_stb/i_data/o_busy          word write handshake
//   o_count/o_idle               FIFO occupancy and engine-idle status
//   o_tx_stb/o_tx_data/i_tx_busy character handshake toward the UART
interface hex_word_tx_if #(
  parameter int W     = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          i_stb;
  logic [W-1:0]  i_data;
  logic          o_busy;
  logic [CW-1:0] o_count;
  logic          o_idle;
  logic          o_tx_stb;
  logic [7:0]    o_tx_data;
  logic          i_tx_busy;

  modport master (
    output i_stb, i_data, i_tx_busy,
    input  o_busy, o_count, o_idle, o_tx_stb, o_tx_data
  );

  modport slave (
    input  i_stb, i_data, i_tx_busy,
    output o_busy, o_count, o_idle, o_tx_stb, o_tx_data
  );
endinterface

// File: rtl/hex_word_tx.sv
// hex_word_tx: queues W-bit words in a DEPTH-entry FIFO and prints each one as
// ASCII hex (MSB nibble first) with optional "0x" prefix and "\r\n" terminator.
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : hex_word_tx_if slave (word write, FIFO status, character stream)
// All outputs are registered; the character registers are loaded from the
// next-state values so o_tx_stb/o_tx_data always describe the current state.
module hex_word_tx #(
  parameter int W       = 32,
  parameter int DEPTH   = 4,
  parameter int PREFIX  = 1,
  parameter int NEWLINE = 1,
  parameter int UPPER   = 0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  hex_word_tx_if.slave bus
);
  localparam int N   = W / 4;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int DCW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PFX0  = 3'd1,
    ST_PFX1  = 3'd2,
    ST_DIGIT = 3'd3,
    ST_CR    = 3'd4,
    ST_LF    = 3'd5
  } state_t;

  logic [W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_busy;
  logic           r_idle;
  state_t         r_state;
  logic [W-1:0]   r_shift;
  logic [DCW-1:0] r_digit;
  logic           r_tx_stb;
  logic [7:0]     r_tx_data;

  logic           w_push;
  logic           w_pop;
  logic           w_empty;
  logic           w_accept;
  logic           w_word_done;
  logic [CW-1:0]  w_count_nxt;
  state_t         w_state_nxt;
  logic [W-1:0]   w_shift_nxt;
  logic [DCW-1:0] w_digit_nxt;
  logic [7:0]     w_tx_data_nxt;

  // ASCII for one hex nibble; letter case fixed by UPPER.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else if (UPPER != 0) begin
      return 8'h37 + {4'h0, nib};
    end else begin
      return 8'h57 + {4'h0, nib};
    end
  endfunction

  assign w_push   = bus.i_stb && !r_busy;
  assign w_empty  = (r_count == {CW{1'b0}});
  assign w_accept = r_tx_stb && !bus.i_tx_busy;

  // FIFO occupancy after this edge.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   w_count_nxt = r_count - {{(CW-1){1'b0}}, 1'b1};
      default: w_count_nxt = r_count;
    endcase
  end

  // Character FSM next state; IDLE is treated as "word done" so the pop/load
  // path is shared between word start and back-to-back words.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_digit_nxt = r_digit;
    w_pop       = 1'b0;
    w_word_done = 1'b0;
    case (r_state)
      ST_IDLE: w_word_done = 1'b1;
      ST_PFX0: begin
        if (w_accept) begin
          w_state_nxt = ST_PFX1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_PFX1: begin
        if (w_accept) begin
          w_state_nxt = ST_DIGIT;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_DIGIT: begin
        if (w_accept) begin
          w_shift_nxt = r_shift << 4;
          if (r_digit == {DCW{1'b0}}) begin
            if (NEWLINE != 0) begin
              w_state_nxt = ST_CR;
            end else begin
              w_word_done = 1'b1;
            end
          end else begin
            w_digit_nxt = r_digit - {{(DCW-1){1'b0}}, 1'b1};
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_CR: begin
        if (w_accept) begin
          w_state_nxt = ST_LF;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_LF: begin
        if (w_accept) begin
          w_word_done = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_word_done && !w_empty) begin
      w_pop       = 1'b1;
      w_shift_nxt = r_mem[r_rd_ptr];
      w_digit_nxt = DCW'(N - 1);
      w_state_nxt = (PREFIX != 0) ? ST_PFX0 : ST_DIGIT;
    end else if (w_word_done) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_pop = 1'b0;
    end
  end

  // Character that the next state presents.
  always_comb begin
    w_tx_data_nxt = 8'h00;
    case (w_state_nxt)
      ST_PFX0:  w_tx_data_nxt = 8'h30;
      ST_PFX1:  w_tx_data_nxt = 8'h78;
      ST_DIGIT: w_tx_data_nxt = hex_char(w_shift_nxt[W-1 -: 4]);
      ST_CR:    w_tx_data_nxt = 8'h0D;
      ST_LF:    w_tx_data_nxt = 8'h0A;
      default:  w_tx_data_nxt = 8'h00;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.i_data;
    end
  end

  // Pointers, status, FSM and character output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr  <= {AW{1'b0}};
      r_rd_ptr  <= {AW{1'b0}};
      r_count   <= {CW{1'b0}};
      r_busy    <= 1'b0;
      r_idle    <= 1'b1;
      r_state   <= ST_IDLE;
      r_shift   <= {W{1'b0}};
      r_digit   <= {DCW{1'b0}};
      r_tx_stb  <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      r_count   <= w_count_nxt;
      r_busy    <= (w_count_nxt == CW'(DEPTH));
      r_idle    <= (w_state_nxt == ST_IDLE) && (w_count_nxt == {CW{1'b0}});
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_digit   <= w_digit_nxt;
      r_tx_stb  <= (w_state_nxt != ST_IDLE);
      r_tx_data <= w_tx_data_nxt;
    end
  end

  assign bus.o_busy    = r_busy;
  assign bus.o_count   = r_count;
  assign bus.o_idle    = r_idle;
  assign bus.o_tx_stb  = r_tx_stb;
  assign bus.o_tx_data = r_tx_data;
endmodule

// File: tb/tb_hex_word_tx.sv
// tb_hex_word_tx: two serializer instances (defaults, and W=16 no-prefix
// no-newline uppercase) driven by directed scenarios and random traffic,
// checked every cycle against a word-level reference model.
module tb_hex_word_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  hex_word_tx_if #(.W(32), .DEPTH(4)) ifa ();
  hex_word_tx_if #(.W(16), .DEPTH(4)) ifb ();

  hex_word_tx #(.W(32), .DEPTH(4), .PREFIX(1), .NEWLINE(1), .UPPER(0)) dut_a (
    .i_clk(clk), .i_reset(rst_a), .bus(ifa));
  hex_word_tx #(.W(16), .DEPTH(4), .PREFIX(0), .NEWLINE(0), .UPPER(1)) dut_b (
    .i_clk(clk), .i_reset(rst_b), .bus(ifb));

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state, index 0 = instance a, 1 = instance b
  logic [63:0] mf [2][64];
  int          mh [2];
  int          ms [2];
  bit          act [2];
  bit          armed [2];
  bit          acc_flag [2];
  logic [63:0] cur [2];
  int          idx [2];
  int          acc_cnt [2];
  logic [7:0]  cap_a [$];
  logic [7:0]  cap_b [$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int p_w(input int k);      return (k == 0) ? 32 : 16; endfunction
  function automatic int p_pfx(input int k);    return (k == 0) ? 1 : 0;   endfunction
  function automatic int p_nl(input int k);     return (k == 0) ? 1 : 0;   endfunction
  function automatic int p_up(input int k);     return (k == 0) ? 0 : 1;   endfunction
  function automatic int nchars(input int k);
    return 2 * p_pfx(k) + p_w(k) / 4 + 2 * p_nl(k);
  endfunction

  // i-th character of the printed form of a word
  function automatic logic [7:0] char_at(input int k, input logic [63:0] word, input int i);
    int n;
    int d;
    int nib;
    n = p_w(k) / 4;
    if (p_pfx(k) == 1 && i == 0) return 8'h30;
    if (p_pfx(k) == 1 && i == 1) return 8'h78;
    d = i - 2 * p_pfx(k);
    if (d < n) begin
      nib = int'((word >> (4 * (n - 1 - d))) & 64'hF);
      if (nib < 10) return 8'(48 + nib);
      return 8'(((p_up(k) == 1) ? 65 : 97) + nib - 10);
    end
    if (d == n) return 8'h0D;
    return 8'h0A;
  endfunction

  // compare this cycle's outputs with the model, then advance the model
  // across the coming edge
  task automatic step(input int k, input logic rst, input logic stb, input logic [63:0] din,
                      input logic txb, input logic o_stb, input logic [7:0] o_data,
                      input logic o_bsy, input logic [7:0] o_cnt, input logic o_idl);
    string nm;
    bit push_ok;
    bit acc;
    nm = (k == 0) ? "a" : "b";
    if (armed[k]) begin
      check_eq({nm, "_stb"}, 64'(o_stb), 64'(act[k]));
      if (act[k]) check_eq({nm, "_data"}, 64'(o_data), 64'(char_at(k, cur[k], idx[k])));
      check_eq({nm, "_count"}, 64'(o_cnt), 64'(ms[k]));
      check_eq({nm, "_busy"}, 64'(o_bsy), 64'(ms[k] == 4));
      check_eq({nm, "_idle"}, 64'(o_idl), 64'(!act[k] && ms[k] == 0));
    end
    acc_flag[k] = 1'b0;
    if (rst) begin
      ms[k] = 0; mh[k] = 0; act[k] = 1'b0; armed[k] = 1'b1;
    end else begin
      push_ok = stb && (ms[k] < 4);
      acc = act[k] && !txb;
      acc_flag[k] = acc;
      if (acc) begin
        if (k == 0) cap_a.push_back(char_at(k, cur[k], idx[k]));
        else        cap_b.push_back(char_at(k, cur[k], idx[k]));
        acc_cnt[k]++;
        idx[k]++;
        if (idx[k] == nchars(k)) act[k] = 1'b0;
      end
      if (!act[k] && ms[k] > 0) begin
        cur[k] = mf[k][mh[k]];
        mh[k] = (mh[k] + 1) % 64;
        ms[k]--;
        idx[k] = 0;
        act[k] = 1'b1;
      end
      if (push_ok) begin
        mf[k][(mh[k] + ms[k]) % 64] = din;
        ms[k]++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step(0, rst_a, ifa.i_stb, 64'(ifa.i_data), ifa.i_tx_busy, ifa.o_tx_stb, ifa.o_tx_data,
         ifa.o_busy, 8'(ifa.o_count), ifa.o_idle);
    step(1, rst_b, ifb.i_stb, 64'(ifb.i_data), ifb.i_tx_busy, ifb.o_tx_stb, ifb.o_tx_data,
         ifb.o_busy, 8'(ifb.o_count), ifb.o_idle);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_a(input string tag, input int budget);
    for (int c = 0; c < budget && !ifa.o_idle; c++) tick();
    check_eq(tag, 64'(ifa.o_idle), 64'd1);
  endtask

  initial begin
    logic [95:0] exp1;
    logic [63:0] exp2;
    logic [31:0] w4 [6];
    int st;
    int hold;
    int c;

    exp1 = {"0xdeadbeef", 8'h0D, 8'h0A};
    exp2 = "00AF0000";
    for (int k = 0; k < 2; k++) begin
      mh[k] = 0; ms[k] = 0; act[k] = 1'b0; armed[k] = 1'b0;
      acc_flag[k] = 1'b0; cur[k] = 64'd0; idx[k] = 0; acc_cnt[k] = 0;
    end
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.i_stb = 1'b0; ifa.i_data = 32'd0; ifa.i_tx_busy = 1'b0;
    ifb.i_stb = 1'b0; ifb.i_data = 16'd0; ifb.i_tx_busy = 1'b0;
    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0;
    check_eq("rst_stb", 64'(ifa.o_tx_stb), 64'd0);
    check_eq("rst_data", 64'(ifa.o_tx_data), 64'h00);
    check_eq("rst_busy", 64'(ifa.o_busy), 64'd0);
    check_eq("rst_count", 64'(ifa.o_count), 64'd0);
    check_eq("rst_idle", 64'(ifa.o_idle), 64'd1);
    tick();

    // 1: one default word, no backpressure, exact latency
    st = cap_a.size();
    ifa.i_stb = 1'b1; ifa.i_data = 32'hDEADBEEF;
    tick();
    ifa.i_stb = 1'b0;
    check_eq("t1_pre_stb", 64'(ifa.o_tx_stb), 64'd0);
    check_eq("t1_cnt1", 64'(ifa.o_count), 64'd1);
    tick();
    check_eq("t1_stb", 64'(ifa.o_tx_stb), 64'd1);
    check_eq("t1_first", 64'(ifa.o_tx_data), 64'h30);
    check_eq("t1_cnt0", 64'(ifa.o_count), 64'd0);
    wait_idle_a("t1_idle", 100);
    check_eq("t1_len", 64'(cap_a.size() - st), 64'd12);
    for (int i = 0; i < 12; i++) check_eq("t1_char", 64'(cap_a[st + i]), 64'(exp1[95 - 8 * i -: 8]));

    // 2: W=16 uppercase, no prefix/newline, two words back to back
    st = cap_b.size();
    ifb.i_stb = 1'b1; ifb.i_data = 16'h00AF; tick();
    ifb.i_data = 16'h0000; tick();
    ifb.i_stb = 1'b0;
    for (c = 0; c < 100 && !ifb.o_idle; c++) tick();
    check_eq("t2_idle", 64'(ifb.o_idle), 64'd1);
    check_eq("t2_len", 64'(cap_b.size() - st), 64'd8);
    for (int i = 0; i < 8; i++) check_eq("t2_char", 64'(cap_b[st + i]), 64'(exp2[63 - 8 * i -: 8]));

    // 3: three busy cycles after every acceptance
    st = cap_a.size();
    hold = 0;
    ifa.i_stb = 1'b1; ifa.i_data = 32'hDEADBEEF; tick();
    ifa.i_stb = 1'b0;
    for (c = 0; c < 300 && !ifa.o_idle; c++) begin
      if (acc_flag[0]) hold = 3;
      ifa.i_tx_busy = (hold > 0);
      if (hold > 0) hold--;
      tick();
    end
    ifa.i_tx_busy = 1'b0;
    check_eq("t3_idle", 64'(ifa.o_idle), 64'd1);
    check_eq("t3_len", 64'(cap_a.size() - st), 64'd12);
    for (int i = 0; i < 12; i++) check_eq("t3_char", 64'(cap_a[st + i]), 64'(exp1[95 - 8 * i -: 8]));

    // 4: fill FIFO under held busy, sixth word dropped
    st = cap_a.size();
    ifa.i_tx_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w4[i] = $urandom;
      ifa.i_stb = 1'b1; ifa.i_data = w4[i];
      tick();
    end
    ifa.i_stb = 1'b0;
    check_eq("t4_count", 64'(ifa.o_count), 64'd4);
    check_eq("t4_busy", 64'(ifa.o_busy), 64'd1);
    ifa.i_tx_busy = 1'b0;
    wait_idle_a("t4_idle", 400);
    check_eq("t4_len", 64'(cap_a.size() - st), 64'd60);
    for (int w = 0; w < 5; w++)
      for (int i = 0; i < 12; i++)
        check_eq("t4_char", 64'(cap_a[st + 12 * w + i]), 64'(char_at(0, 64'(w4[w]), i)));

    // 5: push on the cycle the last character of a word is accepted
    for (int i = 0; i < 3; i++) begin
      ifa.i_stb = 1'b1; ifa.i_data = $urandom; tick();
    end
    ifa.i_stb = 1'b0;
    for (c = 0; c < 50 && !(ifa.o_tx_stb && ifa.o_tx_data == 8'h0A); c++) tick();
    check_eq("t5_lf_seen", 64'(ifa.o_tx_data), 64'h0A);
    check_eq("t5_cnt_pre", 64'(ifa.o_count), 64'd2);
    ifa.i_stb = 1'b1; ifa.i_data = 32'hCAFE0123; tick();
    ifa.i_stb = 1'b0;
    check_eq("t5_count", 64'(ifa.o_count), 64'd2);
    check_eq("t5_stb", 64'(ifa.o_tx_stb), 64'd1);
    wait_idle_a("t5_idle", 300);

    // 6: reset after the fourth character with two words queued
    st = acc_cnt[0];
    ifa.i_stb = 1'b1; ifa.i_data = 32'h12345678; tick();
    ifa.i_data = 32'h9ABCDEF0; tick();
    ifa.i_data = 32'h0F1E2D3C; tick();
    ifa.i_stb = 1'b0;
    for (c = 0; c < 50 && (acc_cnt[0] - st) < 4; c++) tick();
    check_eq("t6_acc4", 64'(acc_cnt[0] - st), 64'd4);
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    check_eq("t6_stb", 64'(ifa.o_tx_stb), 64'd0);
    check_eq("t6_count", 64'(ifa.o_count), 64'd0);
    check_eq("t6_idle", 64'(ifa.o_idle), 64'd1);
    check_eq("t6_busy", 64'(ifa.o_busy), 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t6_quiet", 64'(ifa.o_tx_stb), 64'd0);
    end

    // random traffic on both instances
    for (int r = 0; r < 3000; r++) begin
      ifa.i_stb = ($urandom_range(0, 2) == 0);
      ifa.i_data = $urandom;
      ifa.i_tx_busy = ($urandom_range(0, 1) == 0);
      rst_a = ($urandom_range(0, 499) == 0);
      ifb.i_stb = ($urandom_range(0, 3) == 0);
      ifb.i_data = 16'($urandom);
      ifb.i_tx_busy = ($urandom_range(0, 3) == 0);
      rst_b = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.i_stb = 1'b0; ifa.i_tx_busy = 1'b0;
    ifb.i_stb = 1'b0; ifb.i_tx_busy = 1'b0;
    for (c = 0; c < 600 && !(ifa.o_idle && ifb.o_idle); c++) tick();
    check_eq("drain_a_idle", 64'(ifa.o_idle), 64'd1);
    check_eq("drain_b_idle", 64'(ifb.o_idle), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
